// File: rtl/memctl_arb.sv
// Dual-port on-chip RAM controller: round-robin arbitration between CPU (port 0)
// and DMA/video (port 1), per-byte writes, single registered back-pressurable response.
module memctl_arb #(
    parameter int  DATA_W    = 8,
    parameter int  ADDR_W    = 17,
    parameter int  MEM_WORDS = 65536,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    input  logic [2*BE_W-1:0]   req_be_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int              IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              last_grant_q, last_grant_d;

    logic              occupied_s;
    logic              owner_s;
    logic              free_s;
    logic [1:0]        grant_s;
    logic              accept_s;
    logic              sel_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [BE_W-1:0]   sel_be_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              in_range_s;

    // The response register is one-hot per port, so it also encodes the owner.
    assign occupied_s = |rsp_valid_q;
    assign owner_s    = rsp_valid_q[1];
    assign free_s     = !occupied_s || rsp_ready_i[owner_s];

    // Round-robin grant: on contention the port that did not win last time goes first.
    always_comb begin
        grant_s = 2'b00;
        if (free_s) begin
            case (req_valid_i)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready_o = grant_s;
    assign accept_s    = |grant_s;
    assign sel_s       = grant_s[1];

    // Payload of the granted port.
    always_comb begin
        sel_we_s    = sel_s ? req_we_i[1] : req_we_i[0];
        sel_addr_s  = sel_s ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        sel_wdata_s = sel_s ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
        sel_be_s    = sel_s ? req_be_i[2*BE_W-1:BE_W] : req_be_i[BE_W-1:0];
        sel_idx_s   = sel_addr_s[IDX_W-1:0];
        in_range_s  = ({1'b0, sel_addr_s} < MEM_LIMIT);
    end

    // Response register next state; an accept reloads it even while it is being drained.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            rsp_valid_d  = grant_s;
            last_grant_d = sel_s;
            if (!in_range_s) begin
                rsp_rdata_d = {DATA_W{1'b0}};
                rsp_err_d   = 1'b1;
            end else if (sel_we_s) begin
                rsp_rdata_d = {DATA_W{1'b0}};
                rsp_err_d   = 1'b0;
            end else begin
                rsp_rdata_d = mem_q[sel_idx_s];
                rsp_err_d   = 1'b0;
            end
        end else if (occupied_s && rsp_ready_i[owner_s]) begin
            rsp_valid_d = 2'b00;
            rsp_rdata_d = {DATA_W{1'b0}};
            rsp_err_d   = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Control and response state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= {DATA_W{1'b0}};
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // RAM array is not reset; only enabled byte lanes of an in-range write change.
    always_ff @(posedge clk) begin
        if (accept_s && sel_we_s && in_range_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be_s[b]) begin
                    mem_q[sel_idx_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_memctl_arb.sv
// Directed and random bench for memctl_arb (32-bit data, 1000-word RAM) against a
// transaction-level reference model.
module tb_memctl_arb;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    v = 2'b00, we = 2'b00, rr = 2'b11;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [3:0]    b0 = '0, b1 = '0;
    logic [1:0]    req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [DW-1:0] ref_mem   [4096];
    logic [3:0]    ref_known [4096];
    bit            pq_valid = 1'b0;
    int            pq_owner = 0;
    logic [DW-1:0] pq_data, pq_mask;
    logic          pq_err;
    int            last_p = 1;
    logic [1:0]    exp_g = 2'b00, obs_g = 2'b00;

    memctl_arb #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(v),
        .req_ready_o(req_ready),
        .req_we_i   (we),
        .req_addr_i ({a1, a0}),
        .req_wdata_i({d1, d0}),
        .req_be_i   ({b1, b0}),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rr),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] bmask(input logic [3:0] k);
        logic [DW-1:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = k[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic set_req(input int p, input logic vv, input logic w,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] bb);
        v[p]  = vv;
        we[p] = w;
        if (p == 0) begin a0 = ad; d0 = wd; b0 = bb; end
        else        begin a1 = ad; d1 = wd; b1 = bb; end
    endtask

    // One clock: check grant before the edge, advance the model, check the response after.
    task automatic step();
        logic [1:0]    g;
        int            p;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [3:0]    bb;
        #1;
        g = 2'b00;
        if (!pq_valid || rr[pq_owner]) begin
            if (v == 2'b11) g = (last_p == 0) ? 2'b10 : 2'b01;
            else            g = v;
        end
        exp_g = g;
        obs_g = req_ready;
        chk("req_ready", req_ready, g);
        @(posedge clk);
        if (pq_valid && rr[pq_owner]) pq_valid = 1'b0;
        if (g != 2'b00) begin
            p  = g[1] ? 1 : 0;
            ad = p ? a1 : a0;
            wd = p ? d1 : d0;
            bb = p ? b1 : b0;
            last_p   = p;
            pq_valid = 1'b1;
            pq_owner = p;
            pq_mask  = '1;
            pq_data  = '0;
            pq_err   = 1'b0;
            if (int'(ad) >= MW) begin
                pq_err = 1'b1;
            end else if (we[p]) begin
                for (int i = 0; i < 4; i++) begin
                    if (bb[i]) begin
                        ref_mem[ad][i*8 +: 8] = wd[i*8 +: 8];
                        ref_known[ad][i]      = 1'b1;
                    end
                end
            end else begin
                pq_data = ref_mem[ad];
                pq_mask = bmask(ref_known[ad]);
            end
        end
        #1;
        chk("rsp_valid", rsp_valid, pq_valid ? (pq_owner == 1 ? 2'b10 : 2'b01) : 2'b00);
        if (pq_valid) begin
            chk("rsp_rdata", rsp_rdata & pq_mask, pq_data & pq_mask);
            chk("rsp_err", rsp_err, pq_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 4'h0;
        end

        // reset state
        #1;
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_req_ready_idle", req_ready, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single-byte write then read back
        rr = 2'b11;
        set_req(0, 1'b1, 1'b1, 12'h010, 32'h0000005A, 4'h1);
        step();
        chk("wr_ready_same_cycle", obs_g, 2'b01);
        chk("wr_rsp_rdata_zero", rsp_rdata, 32'h0);
        set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("rd_byte0", rsp_rdata[7:0], 8'h5A);

        // partial-byte merge
        set_req(0, 1'b1, 1'b1, 12'h020, 32'h11223344, 4'hF);
        step();
        set_req(0, 1'b1, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101);
        step();
        set_req(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        step();
        chk("be_merge", rsp_rdata, 32'h11BB33DD);

        // both ports reading every cycle: grants alternate
        set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) step();

        // port 1 response stalled while port 0 waits
        set_req(0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        set_req(1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        step();
        set_req(1, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0);
        set_req(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        rr = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_grant", obs_g, 2'b00);
            chk("stall_rdata_stable", rsp_rdata, 32'h11BB33DD);
        end
        rr = 2'b11;
        step();
        chk("release_grant_p0", obs_g, 2'b01);
        chk("release_rsp_p0", rsp_valid, 2'b01);

        // out-of-range accesses
        set_req(0, 1'b1, 1'b1, 12'd999, 32'hCAFEF00D, 4'hF);
        step();
        set_req(0, 1'b1, 1'b1, 12'd1000, 32'h12345678, 4'hF);
        step();
        chk("oor_write_err", rsp_err, 1'b1);
        set_req(0, 1'b1, 1'b0, 12'd999, 32'h0, 4'h0);
        step();
        chk("edge_999_unchanged", rsp_rdata, 32'hCAFEF00D);
        set_req(0, 1'b1, 1'b0, 12'd1000, 32'h0, 4'h0);
        step();
        chk("oor_read_err", rsp_err, 1'b1);
        chk("oor_read_rdata", rsp_rdata, 32'h0);

        // random traffic; a refused request holds valid and payload
        v = 2'b00;
        exp_g = 2'b00;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(v[p] && !exp_g[p])) begin
                    int r;
                    logic [AW-1:0] ad;
                    r  = int'($urandom_range(0, 19));
                    ad = (r < 16) ? AW'(16 + r) : AW'(998 + r - 16);
                    set_req(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                            ad, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            rr = 2'($urandom_range(0, 3));
            step();
        end

        // async reset with a response pending
        v  = 2'b00;
        rr = 2'b11;
        step();
        set_req(1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        rr = 2'b00;
        step();
        v = 2'b00;
        step();
        chk("pending_before_reset", rsp_valid, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid, 2'b00);
        chk("async_rst_rdata", rsp_rdata, 32'h0);
        chk("async_rst_err", rsp_err, 1'b0);
        pq_valid = 1'b0;
        last_p   = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr = 2'b11;
        set_req(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        chk("post_reset_first_grant", obs_g, 2'b01);
        v = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
